// File: rtl/mult_iter_if.sv
// Handshake and data bundle for the iterative multiplier.
// Latency: none; this interface only carries signals.
// Backpressure: the slave ignores start while busy is high; the master watches busy and done.
// Ports (slave view): start, signed_mode, a, b in; product, busy, done out.
interface mult_iter_if #(
  parameter int N = 16
);
  logic           start;
  logic           signed_mode;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  modport master (
    output start, signed_mode, a, b,
    input  product, busy, done
  );

  modport slave (
    input  start, signed_mode, a, b,
    output product, busy, done
  );
endinterface

// File: rtl/mult_iter.sv
// Iterative N x N multiplier, unsigned or signed per operation, retiring K multiplier bits per cycle.
// Latency: done pulses N/K cycles after the accepting start edge; throughput is one result per N/K+1 cycles.
// Backpressure: start is sampled only while idle; a start seen while busy is dropped, not queued.
// Ports: clk, reset_n (async active-low); bus (mult_iter_if.slave): start, signed_mode, a, b -> product, busy, done.
module mult_iter #(
  parameter int N = 16,
  parameter int K = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  mult_iter_if.slave bus
);

  localparam int DIGITS = N / K;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  if (N < 2) begin : g_bad_n
    $error("mult_iter: N must be at least 2");
  end
  if (K < 1 || (N % K) != 0) begin : g_bad_k
    $error("mult_iter: K must divide N");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           load;
  logic           step;
  logic           finish;

  // The multiplicand is kept pre-shifted so each digit's weight is applied
  // by a fixed shift per cycle instead of a cnt-dependent barrel shifter.
  logic [2*N-1:0] mcand_sh;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] partial;
  logic [2*N-1:0] acc_sum;
  logic [2*N-1:0] product_q;
  logic           done_q;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;

  // Magnitudes in N-bit unsigned: -2^(N-1) negates to itself, which reads
  // correctly as +2^(N-1) when treated as unsigned.
  assign a_mag = (bus.signed_mode && bus.a[N-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.signed_mode && bus.b[N-1]) ? -bus.b : bus.b;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One K-bit digit times the multiplicand, as a sum of shifted copies.
  always_comb begin
    partial = '0;
    for (int i = 0; i < K; i++) begin
      if (mplier[i]) begin
        partial = partial + (mcand_sh << i);
      end
    end
  end

  assign acc_sum = acc + partial;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mcand_sh  <= '0;
      mplier    <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= finish;
      if (load) begin
        mcand_sh <= {{N{1'b0}}, a_mag};
        mplier   <= b_mag;
        neg      <= bus.signed_mode & (bus.a[N-1] ^ bus.b[N-1]);
        acc      <= '0;
        cnt      <= '0;
      end else if (step) begin
        acc      <= acc_sum;
        mcand_sh <= mcand_sh << K;
        mplier   <= mplier >> K;
        cnt      <= cnt + CW'(1);
        // product only moves here, so the running sum never leaks out.
        if (finish) begin
          product_q <= neg ? -acc_sum : acc_sum;
        end
      end
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule
